// File: rtl/ravan_pkg.sv
// Shared RAVAN definitions: key geometry and the key loader state encoding.
package ravan_pkg;

  localparam int unsigned RAVAN_WORD_W = 64;
  localparam int unsigned RAVAN_KEY_W  = 512;

  typedef enum logic [1:0] {
    KL_IDLE,
    KL_LOAD,
    KL_SETTLE,
    KL_READY
  } key_ld_state_t;

endpackage

// File: rtl/ravan_key_loader.sv
// Assembles the master key from word beats into a shadow register and commits it
// atomically to key_out, then holds key_valid low while the hashing pipeline settles.
module ravan_key_loader
  import ravan_pkg::*;
#(
  parameter int unsigned WORD_W  = RAVAN_WORD_W,
  parameter int unsigned N_WORDS = RAVAN_KEY_W / RAVAN_WORD_W,
  parameter int unsigned SETTLE  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kw_valid,
  output logic                          kw_ready,
  input  logic [WORD_W-1:0]             kw_data,
  input  logic                          kw_last,
  input  logic                          clear,
  output logic [WORD_W*N_WORDS-1:0]     key_out,
  output logic                          key_valid,
  output logic                          load_err,
  output logic [$clog2(N_WORDS):0]      word_cnt
);

  localparam int unsigned KEY_W = WORD_W * N_WORDS;
  localparam int unsigned CNT_W = $clog2(N_WORDS) + 1;
  localparam int unsigned SET_W = 8;

  key_ld_state_t    state;
  key_ld_state_t    state_next;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] merged;
  logic [SET_W-1:0] settle_cnt;
  logic             has_key;
  logic             accept;
  logic             is_final;
  logic             commit;
  logic             bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= KL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, load outcome decode and shadow merge of the incoming word
  always_comb begin
    state_next = state;
    accept     = kw_valid && kw_ready;
    is_final   = (word_cnt == CNT_W'(N_WORDS - 1));
    commit     = accept && kw_last && is_final;
    bad        = accept && (kw_last != is_final);
    merged     = shadow;
    for (int i = 0; i < int'(N_WORDS); i++) begin
      if (word_cnt == CNT_W'(i)) begin
        merged[WORD_W*i +: WORD_W] = kw_data;
      end
    end

    unique case (state)
      KL_IDLE, KL_LOAD, KL_READY: begin
        if (commit) begin
          state_next = KL_SETTLE;
        end else if (bad) begin
          state_next = has_key ? KL_READY : KL_IDLE;
        end else if (accept) begin
          state_next = KL_LOAD;
        end
      end
      KL_SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = KL_READY;
        end
      end
      default: state_next = KL_IDLE;
    endcase

    // Zeroize wins over any word arriving in the same cycle
    if (clear) begin
      state_next = KL_IDLE;
    end
  end

  // Datapath: shadow assembly, committed key, settle countdown and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      has_key    <= 1'b0;
      load_err   <= 1'b0;
      word_cnt   <= '0;
      settle_cnt <= '0;
      kw_ready   <= 1'b1;
    end else if (clear) begin
      shadow     <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      has_key    <= 1'b0;
      load_err   <= 1'b0;
      word_cnt   <= '0;
      settle_cnt <= '0;
      kw_ready   <= 1'b1;
    end else begin
      load_err <= bad;
      kw_ready <= (state_next != KL_SETTLE);
      if (commit) begin
        key_out    <= merged;
        shadow     <= '0;
        word_cnt   <= '0;
        key_valid  <= 1'b0;
        has_key    <= 1'b1;
        settle_cnt <= SET_W'(SETTLE - 1);
      end else if (bad) begin
        shadow   <= '0;
        word_cnt <= '0;
      end else if (accept) begin
        shadow   <= merged;
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (state == KL_SETTLE) begin
        if (settle_cnt == '0) begin
          key_valid <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt - SET_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ravan_key_loader.sv
// Scoreboard bench for ravan_key_loader: randomized key loads against a transaction-level key model.
module tb_ravan_key_loader;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned N_WORDS = 8;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned KEY_W   = WORD_W * N_WORDS;

  typedef struct {
    bit               is_err;
    logic [KEY_W-1:0] key;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              kw_valid = 1'b0;
  logic              kw_ready;
  logic [WORD_W-1:0] kw_data = '0;
  logic              kw_last = 1'b0;
  logic              clear = 1'b0;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              load_err;
  logic [3:0]        word_cnt;

  int checks = 0;
  int errors = 0;

  ev_t              exp_q[$];
  bit               mon_en = 1'b0;
  logic [KEY_W-1:0] prev_key = '0;

  logic [KEY_W-1:0] m_key = '0;
  bit               m_has_key = 1'b0;

  ravan_key_loader #(
    .WORD_W (WORD_W),
    .N_WORDS(N_WORDS),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .kw_valid (kw_valid),
    .kw_ready (kw_ready),
    .kw_data  (kw_data),
    .kw_last  (kw_last),
    .clear    (clear),
    .key_out  (key_out),
    .key_valid(key_valid),
    .load_err (load_err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every load_err pulse and every key_out change must match the next queued event
  always @(negedge clk) begin
    if (mon_en) begin
      if (load_err !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load_err: got %b with no event expected", load_err);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (!e.is_err || load_err !== 1'b1) begin
            errors++;
            $display("FAIL err_event: got load_err=%b expected key change to %0h", load_err, e.key);
          end
        end
      end
      if (key_out !== prev_key) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key_change: got %0h", key_out);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.is_err || key_out !== e.key) begin
            errors++;
            $display("FAIL key_event: got %0h expected err=%0b key %0h", key_out, e.is_err, e.key);
          end
        end
      end
      prev_key = key_out;
    end
  end

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] k;
    for (int i = 0; i < int'(KEY_W / 32); i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic void push_key(input logic [KEY_W-1:0] k);
    ev_t e;
    e.is_err = 1'b0;
    e.key    = k;
    if (k !== m_key) exp_q.push_back(e);
  endfunction

  function automatic void push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.key    = '0;
    exp_q.push_back(e);
  endfunction

  // Drives one word; caller is always at posedge+1
  task automatic send_word(input logic [WORD_W-1:0] d, input bit last, input int gap, input bit clr);
    int n;
    kw_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    n = 0;
    while (kw_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (kw_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got kw_ready=%b expected 1 within 50 cycles", kw_ready);
    end
    kw_valid = 1'b1;
    kw_data  = d;
    kw_last  = last;
    clear    = clr;
    @(posedge clk); #1;
    kw_valid = 1'b0;
    kw_last  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k, input int max_gap);
    for (int i = 0; i < int'(N_WORDS); i++) begin
      if (i == int'(N_WORDS) - 1) push_key(k);
      send_word(k[WORD_W*i +: WORD_W], i == int'(N_WORDS) - 1, $urandom_range(0, max_gap), 1'b0);
      if (i < int'(N_WORDS) - 1) begin
        chk("word_cnt_inc", KEY_W'(word_cnt), KEY_W'(i + 1));
        chk("key_valid_hold", KEY_W'(key_valid), KEY_W'(m_has_key));
        chk("key_out_hold", key_out, m_key);
      end
    end
    chk("commit_key", key_out, k);
    chk("commit_word_cnt", KEY_W'(word_cnt), '0);
    for (int c = 0; c < int'(SETTLE); c++) begin
      chk("settle_key_valid", KEY_W'(key_valid), '0);
      chk("settle_kw_ready", KEY_W'(kw_ready), '0);
      @(posedge clk); #1;
    end
    chk("settled_key_valid", KEY_W'(key_valid), KEY_W'(1));
    chk("settled_kw_ready", KEY_W'(kw_ready), KEY_W'(1));
    m_key     = k;
    m_has_key = 1'b1;
  endtask

  // n words; the final one is malformed (early last, or missing last on word N_WORDS)
  task automatic err_load(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      bit last;
      last = (i == n - 1) && (n < int'(N_WORDS));
      if (i == n - 1) push_err();
      send_word(rand_word(), last, $urandom_range(0, max_gap), 1'b0);
      if (i < n - 1) chk("err_word_cnt_inc", KEY_W'(word_cnt), KEY_W'(i + 1));
    end
    chk("err_word_cnt", KEY_W'(word_cnt), '0);
    chk("err_key_out", key_out, m_key);
    chk("err_key_valid", KEY_W'(key_valid), KEY_W'(m_has_key));
    chk("err_kw_ready", KEY_W'(kw_ready), KEY_W'(1));
  endtask

  initial begin
    logic [KEY_W-1:0] k;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_key_out", key_out, '0);
    chk("rst_key_valid", KEY_W'(key_valid), '0);
    chk("rst_kw_ready", KEY_W'(kw_ready), KEY_W'(1));
    chk("rst_load_err", KEY_W'(load_err), '0);
    chk("rst_word_cnt", KEY_W'(word_cnt), '0);
    prev_key = '0;
    mon_en   = 1'b1;

    // Sequential words 1..8 back-to-back
    for (int i = 0; i < int'(N_WORDS); i++) k[WORD_W*i +: WORD_W] = WORD_W'(i + 1);
    load_key(k, 0);
    chk("seq_low_word", KEY_W'(key_out[63:0]), KEY_W'(1));
    chk("seq_high_word", KEY_W'(key_out[511:448]), KEY_W'(8));

    // Reload from READY with gaps
    load_key(rand_key(), 3);

    // kw_last on the 5th word, then a clean load
    err_load(5, 2);
    load_key(rand_key(), 1);

    // Eight words without kw_last
    err_load(8, 2);

    // clear together with the final word
    k = rand_key();
    for (int i = 0; i < int'(N_WORDS) - 1; i++) send_word(k[WORD_W*i +: WORD_W], 1'b0, 0, 1'b0);
    push_key('0);
    send_word(k[WORD_W*(N_WORDS-1) +: WORD_W], 1'b1, 0, 1'b1);
    m_key     = '0;
    m_has_key = 1'b0;
    chk("clr_key_out", key_out, '0);
    chk("clr_key_valid", KEY_W'(key_valid), '0);
    chk("clr_word_cnt", KEY_W'(word_cnt), '0);
    chk("clr_kw_ready", KEY_W'(kw_ready), KEY_W'(1));
    @(posedge clk); #1;
    chk("clr_load_err", KEY_W'(load_err), '0);

    // Error with no key held returns to idle (key_valid stays low)
    err_load(3, 0);
    load_key(rand_key(), 0);

    // rst during SETTLE
    k = rand_key();
    for (int i = 0; i < int'(N_WORDS); i++) begin
      if (i == int'(N_WORDS) - 1) push_key(k);
      send_word(k[WORD_W*i +: WORD_W], i == int'(N_WORDS) - 1, 0, 1'b0);
    end
    m_key = k;
    @(posedge clk); #1;
    push_key('0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_key     = '0;
    m_has_key = 1'b0;
    chk("srst_key_out", key_out, '0);
    chk("srst_key_valid", KEY_W'(key_valid), '0);
    chk("srst_kw_ready", KEY_W'(kw_ready), KEY_W'(1));
    chk("srst_load_err", KEY_W'(load_err), '0);
    chk("srst_word_cnt", KEY_W'(word_cnt), '0);
    load_key(rand_key(), 1);

    // Random mix of good and malformed loads
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) == 0) err_load(int'($urandom_range(1, 8)), 2);
      else load_key(rand_key(), 2);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", KEY_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
